// File: rtl/inferencia_regras_if.sv
// ---------------------------------------------------------------------------
// inferencia_regras_if
// Bus between the rule control unit (master) and the interval type-2
// inference block (slave).
//   Reset_Inf         : synchronous clear of the inference accumulators
//   clk_int           : rule strobe level (treated as data in the clk domain)
//   Sequencia_regras  : current rule index r = 3*i + j (0..8)
//   FOU_ativo         : active-term flags, [2:0] x1 terms, [5:3] x2 terms
//   mu_sup_x1/x2      : upper membership degrees, term t in [8t+7:8t]
//   mu_inf_x1/x2      : lower membership degrees, term t in [8t+7:8t]
//   F_sup / F_inf     : aggregated upper/lower firing strength per output term
//   Inf_pronto        : one-cycle pulse when the rule set is complete
//   estado            : current FSM state (test visibility)
// ---------------------------------------------------------------------------
interface inferencia_regras_if;
  logic        Reset_Inf;
  logic        clk_int;
  logic [3:0]  Sequencia_regras;
  logic [5:0]  FOU_ativo;
  logic [23:0] mu_sup_x1;
  logic [23:0] mu_inf_x1;
  logic [23:0] mu_sup_x2;
  logic [23:0] mu_inf_x2;
  logic [23:0] F_sup;
  logic [23:0] F_inf;
  logic        Inf_pronto;
  logic [1:0]  estado;

  modport master (
    output Reset_Inf, clk_int, Sequencia_regras, FOU_ativo,
           mu_sup_x1, mu_inf_x1, mu_sup_x2, mu_inf_x2,
    input  F_sup, F_inf, Inf_pronto, estado
  );

  modport slave (
    input  Reset_Inf, clk_int, Sequencia_regras, FOU_ativo,
           mu_sup_x1, mu_inf_x1, mu_sup_x2, mu_inf_x2,
    output F_sup, F_inf, Inf_pronto, estado
  );
endinterface

// File: rtl/inferencia_regras.sv
// ---------------------------------------------------------------------------
// inferencia_regras
// Interval type-2 fuzzy rule inference for a 3x3 rule base (two inputs with
// three terms each). Each rule strobe computes upper/lower firing strengths
// with min (stage 1) and aggregates them per output term with max (stage 2).
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : inferencia_regras_if.slave (rule inputs, F_sup/F_inf, Inf_pronto,
//          estado)
// Configuration:
//   INF_FOU_MASK_EN : when defined, a rule whose x1 or x2 term is inactive in
//                     FOU_ativo contributes zero but still counts toward
//                     completion.
// ---------------------------------------------------------------------------
module inferencia_regras (
  input  logic               clk,
  input  logic               rst,
  inferencia_regras_if.slave bus
);

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    ACUMULA = 2'b01,
    PRONTO  = 2'b10
  } estado_t;

  function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] termo(input logic [23:0] v, input logic [1:0] t);
    case (t)
      2'd0:    return v[7:0];
      2'd1:    return v[15:8];
      2'd2:    return v[23:16];
      default: return 8'd0;
    endcase
  endfunction

  logic            clk_int_prev_r;
  logic            armado_r;
  logic            strobe_s;
  logic            regra_ok_s;
  logic            aceita_s;
  logic [1:0]      i_s;
  logic [1:0]      j_s;
  logic [2:0]      soma_s;
  logic [1:0]      k_s;
  logic [7:0]      sup1_s;
  logic [7:0]      sup2_s;
  logic [7:0]      inf1_s;
  logic [7:0]      inf2_s;
  logic [7:0]      fs_sup_s;
  logic [7:0]      fs_inf_s;

  logic            s1_valid_r;
  logic            s1_ultima_r;
  logic [1:0]      s1_k_r;
  logic [7:0]      s1_sup_r;
  logic [7:0]      s1_inf_r;

  logic [2:0][7:0] f_sup_r;
  logic [2:0][7:0] f_inf_r;
  logic            ultima_acum_r;
  estado_t         estado_r;
  logic            inf_pronto_r;

  // Rule strobe detection; armado_r blocks a strobe while clk_int is still
  // high from before reset release, until clk_int has been seen low.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_int_prev_r <= 1'b0;
      armado_r       <= ~bus.clk_int;
    end else begin
      clk_int_prev_r <= bus.clk_int;
      armado_r       <= armado_r | ~bus.clk_int;
    end
  end

  assign strobe_s = bus.clk_int & ~clk_int_prev_r & armado_r;
  assign aceita_s = strobe_s & regra_ok_s & ~bus.Reset_Inf;

  // Decode rule index into x1 term i and x2 term j; indices above 8 are invalid.
  always_comb begin
    i_s        = 2'd0;
    j_s        = 2'd0;
    regra_ok_s = 1'b1;
    case (bus.Sequencia_regras)
      4'd0:    begin i_s = 2'd0; j_s = 2'd0; end
      4'd1:    begin i_s = 2'd0; j_s = 2'd1; end
      4'd2:    begin i_s = 2'd0; j_s = 2'd2; end
      4'd3:    begin i_s = 2'd1; j_s = 2'd0; end
      4'd4:    begin i_s = 2'd1; j_s = 2'd1; end
      4'd5:    begin i_s = 2'd1; j_s = 2'd2; end
      4'd6:    begin i_s = 2'd2; j_s = 2'd0; end
      4'd7:    begin i_s = 2'd2; j_s = 2'd1; end
      4'd8:    begin i_s = 2'd2; j_s = 2'd2; end
      default: regra_ok_s = 1'b0;
    endcase
  end

  // Output term from i+j: {0,1} -> 0, 2 -> 1, {3,4} -> 2.
  always_comb begin
    soma_s = {1'b0, i_s} + {1'b0, j_s};
    case (soma_s)
      3'd0, 3'd1: k_s = 2'd0;
      3'd2:       k_s = 2'd1;
      3'd3, 3'd4: k_s = 2'd2;
      default:    k_s = 2'd0;
    endcase
  end

  // Firing strengths; lower degrees are clamped so the interval never inverts.
  always_comb begin
    sup1_s   = termo(bus.mu_sup_x1, i_s);
    sup2_s   = termo(bus.mu_sup_x2, j_s);
    inf1_s   = min8(termo(bus.mu_inf_x1, i_s), sup1_s);
    inf2_s   = min8(termo(bus.mu_inf_x2, j_s), sup2_s);
`ifdef INF_FOU_MASK_EN
    if (bus.FOU_ativo[{1'b0, i_s}] && bus.FOU_ativo[3'd3 + {1'b0, j_s}]) begin
      fs_sup_s = min8(sup1_s, sup2_s);
      fs_inf_s = min8(inf1_s, inf2_s);
    end else begin
      fs_sup_s = 8'd0;
      fs_inf_s = 8'd0;
    end
`else
    fs_sup_s = min8(sup1_s, sup2_s);
    fs_inf_s = min8(inf1_s, inf2_s);
`endif
  end

  // Stage 1: register firing strengths, output term and last-rule flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_ultima_r <= 1'b0;
      s1_k_r      <= 2'd0;
      s1_sup_r    <= 8'd0;
      s1_inf_r    <= 8'd0;
    end else if (bus.Reset_Inf) begin
      s1_valid_r  <= 1'b0;
      s1_ultima_r <= 1'b0;
    end else begin
      s1_valid_r <= aceita_s;
      if (aceita_s) begin
        s1_ultima_r <= (bus.Sequencia_regras == 4'd8);
        s1_k_r      <= k_s;
        s1_sup_r    <= fs_sup_s;
        s1_inf_r    <= fs_inf_s;
      end
    end
  end

  // Stage 2: max-aggregation into the per-term accumulators.
  always_ff @(posedge clk) begin
    if (rst || bus.Reset_Inf) begin
      f_sup_r       <= '0;
      f_inf_r       <= '0;
      ultima_acum_r <= 1'b0;
    end else begin
      ultima_acum_r <= s1_valid_r & s1_ultima_r;
      if (s1_valid_r) begin
        f_sup_r[s1_k_r] <= max8(f_sup_r[s1_k_r], s1_sup_r);
        f_inf_r[s1_k_r] <= max8(f_inf_r[s1_k_r], s1_inf_r);
      end
    end
  end

  // Control FSM; Inf_pronto is registered alongside the PRONTO state.
  always_ff @(posedge clk) begin
    if (rst || bus.Reset_Inf) begin
      estado_r     <= OCIOSO;
      inf_pronto_r <= 1'b0;
    end else begin
      case (estado_r)
        OCIOSO: begin
          inf_pronto_r <= 1'b0;
          if (aceita_s) estado_r <= ACUMULA;
        end
        ACUMULA: begin
          if (ultima_acum_r) begin
            estado_r     <= PRONTO;
            inf_pronto_r <= 1'b1;
          end else begin
            inf_pronto_r <= 1'b0;
          end
        end
        PRONTO: begin
          inf_pronto_r <= 1'b0;
          estado_r     <= aceita_s ? ACUMULA : OCIOSO;
        end
        default: begin
          estado_r     <= OCIOSO;
          inf_pronto_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.F_sup      = f_sup_r;
  assign bus.F_inf      = f_inf_r;
  assign bus.Inf_pronto = inf_pronto_r;
  assign bus.estado     = estado_r;

endmodule

// File: tb/tb_inferencia_regras.sv
module tb_inferencia_regras;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   pronto_cnt;

  inferencia_regras_if bus_if();

  inferencia_regras dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial pronto_cnt = 0;
  always @(negedge clk) if (bus_if.Inf_pronto === 1'b1) pronto_cnt = pronto_cnt + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one-cycle clk_int high pulse, then one cycle low; ends with stage 2 done
  task automatic strobe(input logic [3:0] regra);
    bus_if.Sequencia_regras = regra;
    bus_if.clk_int = 1'b1;
    step(1);
    bus_if.clk_int = 1'b0;
    step(1);
  endtask

  task automatic clear_inf();
    bus_if.Reset_Inf = 1'b1;
    step(1);
    bus_if.Reset_Inf = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    tests++; if (bus_if.F_sup !== 24'h000000) begin $display("FAIL reset_fsup: got %h expected %h", bus_if.F_sup, 24'h0); fails++; end
    tests++; if (bus_if.F_inf !== 24'h000000) begin $display("FAIL reset_finf: got %h expected %h", bus_if.F_inf, 24'h0); fails++; end
    tests++; if (bus_if.Inf_pronto !== 1'b0) begin $display("FAIL reset_pronto: got %b expected 0", bus_if.Inf_pronto); fails++; end
    tests++; if (bus_if.estado !== 2'b00) begin $display("FAIL reset_estado: got %b expected 00", bus_if.estado); fails++; end
  endtask

  task automatic test_basic_rule();
    bus_if.mu_sup_x1 = 24'h0000C8;
    bus_if.mu_sup_x2 = 24'h007800;
    bus_if.mu_inf_x1 = 24'h000050;
    bus_if.mu_inf_x2 = 24'h009600;
    bus_if.Sequencia_regras = 4'd1;
    bus_if.clk_int = 1'b1;
    step(1);
    bus_if.clk_int = 1'b0;
    tests++; if (bus_if.F_sup !== 24'h000000) begin $display("FAIL basic_latency: got %h expected %h", bus_if.F_sup, 24'h0); fails++; end
    step(1);
    tests++; if (bus_if.F_sup !== 24'h000078) begin $display("FAIL basic_fsup: got %h expected %h", bus_if.F_sup, 24'h000078); fails++; end
    tests++; if (bus_if.F_inf !== 24'h000050) begin $display("FAIL basic_finf: got %h expected %h", bus_if.F_inf, 24'h000050); fails++; end
    tests++; if (bus_if.estado !== 2'b01) begin $display("FAIL basic_estado: got %b expected 01", bus_if.estado); fails++; end
    clear_inf();
    tests++; if (bus_if.F_sup !== 24'h000000) begin $display("FAIL basic_clear_fsup: got %h expected %h", bus_if.F_sup, 24'h0); fails++; end
    tests++; if (bus_if.estado !== 2'b00) begin $display("FAIL basic_clear_estado: got %b expected 00", bus_if.estado); fails++; end
  endtask

  task automatic test_full_set();
    int base;
    bus_if.mu_sup_x1 = 24'h646464;
    bus_if.mu_sup_x2 = 24'h646464;
    bus_if.mu_inf_x1 = 24'h323232;
    bus_if.mu_inf_x2 = 24'h323232;
    base = pronto_cnt;
    for (int r = 0; r < 9; r++) begin
      strobe(r[3:0]);
      if (r < 8) begin
        tests++; if (bus_if.Inf_pronto !== 1'b0) begin $display("FAIL full_early_pronto: rule %0d got %b expected 0", r, bus_if.Inf_pronto); fails++; end
      end
    end
    tests++; if (bus_if.F_sup !== 24'h646464) begin $display("FAIL full_fsup: got %h expected %h", bus_if.F_sup, 24'h646464); fails++; end
    tests++; if (bus_if.F_inf !== 24'h323232) begin $display("FAIL full_finf: got %h expected %h", bus_if.F_inf, 24'h323232); fails++; end
    tests++; if (bus_if.Inf_pronto !== 1'b0) begin $display("FAIL full_pronto_at_acc: got %b expected 0", bus_if.Inf_pronto); fails++; end
    step(1);
    tests++; if (bus_if.Inf_pronto !== 1'b1) begin $display("FAIL full_pronto: got %b expected 1", bus_if.Inf_pronto); fails++; end
    tests++; if (bus_if.estado !== 2'b10) begin $display("FAIL full_estado_pronto: got %b expected 10", bus_if.estado); fails++; end
    step(1);
    tests++; if (bus_if.estado !== 2'b00) begin $display("FAIL full_estado_ocioso: got %b expected 00", bus_if.estado); fails++; end
    step(4);
    tests++; if (pronto_cnt - base !== 1) begin $display("FAIL full_pulse_count: got %0d expected 1", pronto_cnt - base); fails++; end
    tests++; if (bus_if.F_sup !== 24'h646464) begin $display("FAIL full_hold: got %h expected %h", bus_if.F_sup, 24'h646464); fails++; end
    clear_inf();
  endtask

  task automatic test_order_filter();
    bus_if.mu_sup_x1 = 24'h5A3CC8;
    bus_if.mu_sup_x2 = 24'h46501E;
    bus_if.mu_inf_x1 = 24'h281464;
    bus_if.mu_inf_x2 = 24'h3CFF0A;
    strobe(4'd8);
    step(2);
    strobe(4'd4);
    strobe(4'd0);
    tests++; if (bus_if.F_sup !== 24'h463C1E) begin $display("FAIL order_fsup: got %h expected %h", bus_if.F_sup, 24'h463C1E); fails++; end
    tests++; if (bus_if.F_inf !== 24'h28140A) begin $display("FAIL order_finf: got %h expected %h", bus_if.F_inf, 24'h28140A); fails++; end
    strobe(4'd1);
    strobe(4'd0);
    tests++; if (bus_if.F_sup !== 24'h463C50) begin $display("FAIL order_max_fsup: got %h expected %h", bus_if.F_sup, 24'h463C50); fails++; end
    tests++; if (bus_if.F_inf !== 24'h281450) begin $display("FAIL order_max_finf: got %h expected %h", bus_if.F_inf, 24'h281450); fails++; end
    tests++; if (bus_if.estado !== 2'b01) begin $display("FAIL order_estado: got %b expected 01", bus_if.estado); fails++; end
    strobe(4'd12);
    step(2);
    tests++; if (bus_if.F_sup !== 24'h463C50) begin $display("FAIL filter_fsup: got %h expected %h", bus_if.F_sup, 24'h463C50); fails++; end
    tests++; if (bus_if.F_inf !== 24'h281450) begin $display("FAIL filter_finf: got %h expected %h", bus_if.F_inf, 24'h281450); fails++; end
    tests++; if (bus_if.estado !== 2'b01) begin $display("FAIL filter_estado: got %b expected 01", bus_if.estado); fails++; end
  endtask

  task automatic test_reset_inf_collision();
    // rule 7 would raise F_sup[k2] from 46 to 50 if it got through
    bus_if.Sequencia_regras = 4'd7;
    bus_if.clk_int = 1'b1;
    step(1);
    bus_if.clk_int = 1'b0;
    bus_if.Reset_Inf = 1'b1;
    step(1);
    bus_if.Reset_Inf = 1'b0;
    tests++; if (bus_if.F_sup !== 24'h000000) begin $display("FAIL coll_pend_fsup: got %h expected %h", bus_if.F_sup, 24'h0); fails++; end
    tests++; if (bus_if.F_inf !== 24'h000000) begin $display("FAIL coll_pend_finf: got %h expected %h", bus_if.F_inf, 24'h0); fails++; end
    tests++; if (bus_if.estado !== 2'b00) begin $display("FAIL coll_pend_estado: got %b expected 00", bus_if.estado); fails++; end
    step(3);
    tests++; if (bus_if.F_sup !== 24'h000000) begin $display("FAIL coll_pend_late: got %h expected %h", bus_if.F_sup, 24'h0); fails++; end
    bus_if.Reset_Inf = 1'b1;
    bus_if.clk_int = 1'b1;
    step(1);
    bus_if.Reset_Inf = 1'b0;
    bus_if.clk_int = 1'b0;
    tests++; if (bus_if.estado !== 2'b00) begin $display("FAIL coll_strobe_estado: got %b expected 00", bus_if.estado); fails++; end
    step(3);
    tests++; if (bus_if.F_sup !== 24'h000000) begin $display("FAIL coll_strobe_fsup: got %h expected %h", bus_if.F_sup, 24'h0); fails++; end
    tests++; if (bus_if.estado !== 2'b00) begin $display("FAIL coll_strobe_estado_late: got %b expected 00", bus_if.estado); fails++; end
  endtask

  task automatic test_fou_mask();
    logic [23:0] exp_sup;
`ifdef INF_FOU_MASK_EN
    exp_sup = 24'h000000;
`else
    exp_sup = 24'h0000FF;
`endif
    bus_if.FOU_ativo = 6'b111110;
    $display("[TB] FOU_ativo=%b", bus_if.FOU_ativo);
    bus_if.mu_sup_x1 = 24'hFFFFFF;
    bus_if.mu_sup_x2 = 24'hFFFFFF;
    bus_if.mu_inf_x1 = 24'hFFFFFF;
    bus_if.mu_inf_x2 = 24'hFFFFFF;
    strobe(4'd0);
    tests++; if (bus_if.F_sup !== exp_sup) begin $display("FAIL fou_fsup_k0: got %h expected %h", bus_if.F_sup, exp_sup); fails++; end
    strobe(4'd8);
    step(1);
    tests++; if (bus_if.Inf_pronto !== 1'b1) begin $display("FAIL fou_pronto: got %b expected 1", bus_if.Inf_pronto); fails++; end
    tests++; if (bus_if.F_sup !== (exp_sup | 24'hFF0000)) begin $display("FAIL fou_fsup_k2: got %h expected %h", bus_if.F_sup, exp_sup | 24'hFF0000); fails++; end
    bus_if.FOU_ativo = 6'b111111;
    step(1);
    clear_inf();
  endtask

  task automatic test_reset_behaviour();
    bus_if.mu_sup_x1 = 24'h000040;
    bus_if.mu_sup_x2 = 24'h000040;
    bus_if.mu_inf_x1 = 24'h000020;
    bus_if.mu_inf_x2 = 24'h000020;
    strobe(4'd0);
    tests++; if (bus_if.estado !== 2'b01) begin $display("FAIL rst_pre_estado: got %b expected 01", bus_if.estado); fails++; end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    tests++; if ({bus_if.F_sup, bus_if.F_inf, bus_if.Inf_pronto, bus_if.estado} !== 51'd0) begin $display("FAIL rst_acumula: got %h/%h/%b/%b expected all 0", bus_if.F_sup, bus_if.F_inf, bus_if.Inf_pronto, bus_if.estado); fails++; end
    bus_if.Sequencia_regras = 4'd0;
    bus_if.clk_int = 1'b1;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(3);
    tests++; if (bus_if.F_sup !== 24'h000000) begin $display("FAIL rst_held_fsup: got %h expected %h", bus_if.F_sup, 24'h0); fails++; end
    tests++; if (bus_if.estado !== 2'b00) begin $display("FAIL rst_held_estado: got %b expected 00", bus_if.estado); fails++; end
    bus_if.clk_int = 1'b0;
    step(1);
    strobe(4'd0);
    tests++; if (bus_if.F_sup !== 24'h000040) begin $display("FAIL rst_rearm_fsup: got %h expected %h", bus_if.F_sup, 24'h000040); fails++; end
    tests++; if (bus_if.F_inf !== 24'h000020) begin $display("FAIL rst_rearm_finf: got %h expected %h", bus_if.F_inf, 24'h000020); fails++; end
    tests++; if (bus_if.estado !== 2'b01) begin $display("FAIL rst_rearm_estado: got %b expected 01", bus_if.estado); fails++; end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus_if.Reset_Inf = 1'b0;
    bus_if.clk_int = 1'b0;
    bus_if.Sequencia_regras = 4'd0;
    bus_if.FOU_ativo = 6'b111111;
    bus_if.mu_sup_x1 = 24'h0;
    bus_if.mu_inf_x1 = 24'h0;
    bus_if.mu_sup_x2 = 24'h0;
    bus_if.mu_inf_x2 = 24'h0;
    test_reset();
    test_basic_rule();
    test_full_set();
    test_order_filter();
    test_reset_inf_collision();
    test_fou_mask();
    test_reset_behaviour();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inferencia_regras.md
INFERENCIA_REGRAS -- requirements
Module: inferencia_regras

Interface
REQ-001 clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 Reset_Inf  input  1  synchronous clear of the inference accumulators; driven by the rule control unit.
REQ-004 clk_int  input  1  rule strobe level from the rule control unit, sampled in the clk domain and used only as a data signal.
REQ-005 Sequencia_regras  input  4  index of the current rule, 0..8, with r = 3*i + j, where i is the x1 term and j is the x2 term.
REQ-006 FOU_ativo  input  6  active-term flags: [2:0] are the x1 terms 0..2 and [5:3] are the x2 terms 0..2.
REQ-007 mu_sup_x1, mu_inf_x1, mu_sup_x2, mu_inf_x2  input  24 each  upper and lower membership degrees, with term t in bits [8t+7:8t], unsigned 8-bit.
REQ-008 F_sup, F_inf  output  24 each  aggregated upper and lower firing strengths per output term k (0..2), with term k in bits [8k+7:8k].
REQ-009 Inf_pronto  output  1  one-cycle pulse when the rule set is complete.
REQ-010 estado  output  2  current FSM state, for test.

Function
REQ-011 The block SHALL detect a rule strobe as a rising edge of clk_int: clk_int=1 and the registered previous sample=0.
REQ-012 A strobe with Sequencia_regras > 8 SHALL be ignored, with no state change and no accumulation.
REQ-013 Stage 1 (the registered cycle after the strobe) SHALL perform these operations:
  - clamp each lower degree to min(mu_inf, mu_sup) of the same term;
  - compute fs_sup = min(mu_sup_x1[i], mu_sup_x2[j]);
  - compute fs_inf = min(clamped mu_inf_x1[i], clamped mu_inf_x2[j]);
  - register both results with the output term k and a valid bit.
REQ-014 Output term mapping SHALL be: i+j in {0,1} -> k=0; i+j = 2 -> k=1; i+j in {3,4} -> k=2.
REQ-015 Stage 2 SHALL update the accumulators as F_sup[k] = max(F_sup[k], fs_sup) and F_inf[k] = max(F_inf[k], fs_inf), so an accumulator updates two cycles after the strobe.
REQ-016 Aggregation SHALL be order-independent; repeated rule indices are legal and idempotent.
REQ-017 The FSM SHALL have the states OCIOSO=00, ACUMULA=01 and PRONTO=10.
REQ-018 OCIOSO SHALL move to ACUMULA on the first accepted strobe.
REQ-019 ACUMULA SHALL move to PRONTO in the cycle after rule 8 is accumulated; Inf_pronto=1 only while in PRONTO.
REQ-020 PRONTO SHALL move to OCIOSO after one cycle, and F_sup/F_inf SHALL hold their values until Reset_Inf or rst.
REQ-021 A strobe arriving while in PRONTO SHALL be accepted, and the next state SHALL be ACUMULA.
REQ-022 Reset_Inf=1 SHALL have these effects in the next cycle:
  - clear the accumulators to 0;
  - flush the stage-1 valid bit;
  - set the state to OCIOSO.
  Reset_Inf SHALL take priority over a simultaneous strobe or stage-2 write, and the strobe is dropped.
REQ-023 Arithmetic SHALL be 8-bit unsigned min/max only, with no overflow possible.

Reset
REQ-024 When rst=1 at a clock edge, the block SHALL clear:
  - F_sup and F_inf to 0;
  - Inf_pronto to 0;
  - estado to OCIOSO (00);
  - the stage-1 valid bit and the previous clk_int sample to 0.
REQ-025 rst SHALL take priority over Reset_Inf and the strobe.
REQ-026 If clk_int=1 at reset release, the block SHALL NOT produce a strobe until clk_int has returned to 0.

Configuration
REQ-027 Macro INF_FOU_MASK_EN, when defined: a rule whose FOU_ativo[i] or FOU_ativo[3+j] is 0 SHALL contribute fs_sup=fs_inf=0, but SHALL still count toward completion (rule 8 still triggers PRONTO).
REQ-028 When INF_FOU_MASK_EN is not defined, FOU_ativo SHALL be ignored and all rules SHALL use the membership degrees directly.

Verification
REQ-029 Basic rule: with mu_sup_x1[0]=200, mu_sup_x2[1]=120, mu_inf_x1[0]=80 and mu_inf_x2[1]=150, strobe rule 1 -> two cycles later F_sup[k0]=120 and F_inf[k0]=80 (clamped 150 -> 120, then min(80,120)=80).
REQ-030 Full set: strobe rules 0..8 with all mu_sup=100 and mu_inf=50 -> F_sup=0x646464 and F_inf=0x323232, and Inf_pronto pulses exactly once, one cycle after the rule-8 accumulation.
REQ-031 Ordering and filtering:
  - rules 8,4,0 applied out of order with differing values -> each F term equals the max over its rules;
  - rule index 12 -> ignored, with no change to F and no change to estado.
REQ-032 Reset_Inf collision: assert Reset_Inf in the same cycle as a strobe and with a stage-1 result pending -> next cycle F_sup=F_inf=0 and estado=00, and no later accumulation from the dropped rules.
REQ-033 INF_FOU_MASK_EN defined, FOU_ativo=6'b111110, rule 0 with mu=255 -> F_sup[k0]=0; rule 8 still yields the Inf_pronto pulse. With the macro undefined, the same stimulus -> F_sup[k0]=255.
REQ-034 Reset behaviour:
  - rst during ACUMULA -> all outputs 0 and estado=00 on the next cycle;
  - clk_int held at 1 across reset release -> no accumulation until clk_int goes 0 then 1.
